wait_ram: RTL and testbench
===========================

WAIT_RAM -- requirements
Module: wait_ram

Interface
REQ-001 The block SHALL be single-clock, with synchronous, active-high reset.
REQ-002 Parameter DATA_W, default 16, SHALL set the word width.
REQ-003 Parameter ADDR_W, default 16, SHALL set the address port width.
REQ-004 Parameter DEPTH, default 65536, SHALL set the implemented word count; legal range 1..2**ADDR_W.
REQ-005 Parameter WAIT_CYC, default 4, SHALL set the access latency in cycles; legal range 1..255.
REQ-006 Port CLK  in  1  SHALL be the clock; all state changes on its rising edge.
REQ-007 Port RST  in  1  SHALL be the synchronous active-high reset.
REQ-008 Port CS  in  1  SHALL be the access request, sampled only in IDLE.
REQ-009 Port WE  in  1  SHALL select write (1) or read (0), captured with CS.
REQ-010 Port ADDR  in  ADDR_W  SHALL be the word address, captured with CS.
REQ-011 Port DataIn  in  DATA_W  SHALL be the write data, captured with CS.
REQ-012 Port DataOut  out  DATA_W  SHALL be the registered read data.
REQ-013 Port R  out  1  SHALL be the ready pulse marking access completion.
REQ-014 Port ERR  out  1  SHALL flag an out-of-range access and is valid only while R=1.
REQ-015 Port BUSY  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-017 In IDLE, a CS=1 at an edge SHALL capture WE, ADDR and DataIn, load the counter with WAIT_CYC-1, and enter WAIT.
REQ-018 In WAIT, at each edge, the counter SHALL decrement if nonzero; if it is zero, the FSM SHALL perform the access and enter DONE.
REQ-019 R SHALL rise exactly WAIT_CYC edges after the acceptance edge and remain high for exactly one cycle (the DONE state).
REQ-020 DONE SHALL always return to IDLE at the next edge, so back-to-back accesses are spaced WAIT_CYC+2 cycles apart.
REQ-021 A read SHALL register mem[captured ADDR] into DataOut on the DONE-entry edge, and DataOut SHALL hold until the next read completes.
REQ-022 A write SHALL commit the captured DataIn on the DONE-entry edge, and DataOut SHALL be unchanged by writes (never Z).
REQ-023 If captured ADDR >= DEPTH, the access SHALL be out of range: writes are dropped, reads load DataOut with 0, and ERR=1 with R.
REQ-024 CS, WE, ADDR and DataIn SHALL be ignored outside IDLE, so changes or CS deassertion mid-access do not alter the access in flight.
REQ-025 A read-after-write to the same address SHALL return the newly written data.
REQ-026 The counter SHALL be sized to hold WAIT_CYC-1 and SHALL never wrap.

Reset
REQ-027 RST=1 SHALL force IDLE, counter=0, R=0, ERR=0, BUSY=0 and DataOut=0 at the next edge.
REQ-028 RST asserted during WAIT SHALL abort the access: no write commits and no R pulse.
REQ-029 RST SHALL take priority over CS in the same cycle.
REQ-030 Memory contents SHALL NOT be cleared by RST.

Structure
REQ-031 Package wait_ram_pkg SHALL hold the state enum typedef (IDLE/WAIT/DONE) and the default parameter constants.
REQ-032 Storage SHALL be a sub-module wait_ram_array containing the DEPTH x DATA_W array, with a synchronous write port and a synchronous read port.
REQ-033 The FSM, counter, capture registers and range check SHALL reside in wait_ram.

Verification (DATA_W=16, ADDR_W=16, DEPTH=256, WAIT_CYC=3)
REQ-034 Scenario: write 0x1234 to 0x0010, then read 0x0010 -> R pulses 3 edges after each acceptance, read DataOut=0x1234, ERR=0.
REQ-035 Scenario: read 0x0100 (>= DEPTH) -> DataOut=0x0000, ERR=1 and R=1 in the same cycle; a write to 0x0100 leaves mem unchanged.
REQ-036 Scenario: CS held high continuously for reads of 0x0005 -> accepted every 5 cycles, and R is never high for two consecutive cycles.
REQ-037 Scenario: write 0xBEEF to 0x0020 with RST pulsed at WAIT cycle 2 -> no R pulse, outputs zero, and a later read of 0x0020 returns the prior value.
REQ-038 Scenario: change ADDR and DataIn every cycle during WAIT for write 0xAAAA to 0x0001 -> only mem[0x0001]=0xAAAA is modified.
REQ-039 Scenario: WAIT_CYC=1, read 0x0000 -> R rises at the first edge after acceptance, and BUSY is high for exactly 2 cycles.

Source files
------------

// File: rtl/wait_ram_pkg.sv
// Shared types and default parameters for the wait-state RAM.
package wait_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_W   = 32'd16;
    localparam int unsigned DEF_ADDR_W   = 32'd16;
    localparam int unsigned DEF_DEPTH    = 32'd65536;
    localparam int unsigned DEF_WAIT_CYC = 32'd4;

    // Width just large enough to hold wait_cyc-1, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_cyc);
        return (wait_cyc > 32'd1) ? $clog2(wait_cyc) : 32'd1;
    endfunction

endpackage

// File: rtl/wait_ram_array.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered read port.
module wait_ram_array
    import wait_ram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned AW     = 32'd16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rclr_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port; the array itself has no reset so contents survive RST.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register: clear wins over a read so reset and out-of-range reads give zero.
    always_ff @(posedge clk_i) begin
        if (rclr_i) begin
            rdata_q <= {DATA_W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wait_ram.sv
// Single-port RAM with a fixed access latency, a ready pulse and out-of-range flagging.
module wait_ram
    import wait_ram_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CS,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              R,
    output logic              ERR,
    output logic              BUSY
);

    localparam int unsigned CNT_W  = cnt_width(WAIT_CYC);
    localparam int unsigned MEM_AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              r_q, err_q, busy_q;

    logic              access_s;
    logic              in_range_s;
    logic              mem_we_s;
    logic              mem_re_s;
    logic              rd_clr_s;

    assign in_range_s = (32'(addr_q) < DEPTH);

    // Next-state, countdown and request capture; inputs only matter in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        access_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (CS) begin
                    we_d    = WE;
                    addr_d  = ADDR;
                    din_d   = DataIn;
                    cnt_d   = CNT_W'(WAIT_CYC - 32'd1);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access_s = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A reset arriving on the completing edge suppresses the access entirely.
    assign mem_we_s = access_s & ~RST & we_q & in_range_s;
    assign mem_re_s = access_s & ~RST & ~we_q & in_range_s;
    assign rd_clr_s = RST | (access_s & ~we_q & ~in_range_s);

    // State, capture and status registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            we_q    <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            din_q   <= {DATA_W{1'b0}};
            r_q     <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            r_q     <= access_s;
            err_q   <= access_s & ~in_range_s;
            busy_q  <= (state_d != IDLE);
        end
    end

    wait_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (mem_we_s),
        .waddr_i (addr_q[MEM_AW-1:0]),
        .wdata_i (din_q),
        .re_i    (mem_re_s),
        .rclr_i  (rd_clr_s),
        .raddr_i (addr_q[MEM_AW-1:0]),
        .rdata_o (DataOut)
    );

    assign R    = r_q;
    assign ERR  = err_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_wait_ram.sv
// Directed bench: one instance with WAIT_CYC=3/DEPTH=256 and one with WAIT_CYC=1.
module tb_wait_ram;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cs0, we0, cs1, we1;
    logic [15:0] addr0, din0, addr1, din1;
    logic [15:0] dout0, dout1;
    logic        r0, err0, busy0, r1, err1, busy1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    wait_ram #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(3)) u0 (
        .CLK(CLK), .RST(RST), .CS(cs0), .WE(we0), .ADDR(addr0), .DataIn(din0),
        .DataOut(dout0), .R(r0), .ERR(err0), .BUSY(busy0)
    );

    wait_ram #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(1)) u1 (
        .CLK(CLK), .RST(RST), .CS(cs1), .WE(we1), .ADDR(addr1), .DataIn(din1),
        .DataOut(dout1), .R(r1), .ERR(err1), .BUSY(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at a negedge with it idle again.
    task automatic access(input bit sel, input bit we, input logic [15:0] addr,
                          input logic [15:0] data, input bit scramble,
                          output int lat, output int busy_cnt, output logic [15:0] dout,
                          output logic err, output logic r_after);
        if (sel) begin cs1 = 1'b1; we1 = we; addr1 = addr; din1 = data; end
        else     begin cs0 = 1'b1; we0 = we; addr0 = addr; din0 = data; end
        @(negedge CLK);
        cs0 = 1'b0;
        cs1 = 1'b0;
        lat = 0;
        busy_cnt = sel ? int'(busy1) : int'(busy0);
        while (!(sel ? r1 : r0) && lat < 40) begin
            if (scramble) begin
                addr0 = 16'h0002 + 16'(lat % 2);
                din0  = 16'h5A00 + 16'(lat);
            end
            @(negedge CLK);
            lat++;
            busy_cnt += sel ? int'(busy1) : int'(busy0);
        end
        dout = sel ? dout1 : dout0;
        err  = sel ? err1 : err0;
        @(negedge CLK);
        r_after = sel ? r1 : r0;
        busy_cnt += sel ? int'(busy1) : int'(busy0);
    endtask

    initial begin
        int          lat, bc, npulse, consec, wd;
        int          pos [3];
        logic        e, ra, prev;
        logic [15:0] d;

        RST = 1'b1;
        cs0 = 1'b0; we0 = 1'b0; addr0 = 16'h0000; din0 = 16'h0000;
        cs1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; din1 = 16'h0000;
        repeat (2) @(negedge CLK);
        chk("rst_dout", 32'(dout0), 32'h0);
        chk("rst_r",    32'(r0),    32'h0);
        chk("rst_err",  32'(err0),  32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        access(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, lat, bc, d, e, ra);
        chk("wr10_lat",  32'(lat), 32'd3);
        chk("wr10_err",  32'(e),   32'h0);
        chk("wr10_rone", 32'(ra),  32'h0);
        chk("wr10_busy", 32'(bc),  32'd4);
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, bc, d, e, ra);
        chk("rd10_lat",  32'(lat), 32'd3);
        chk("rd10_data", 32'(d),   32'h1234);
        chk("rd10_err",  32'(e),   32'h0);
        chk("rd10_rone", 32'(ra),  32'h0);

        access(1'b0, 1'b1, 16'h0000, 16'h0F0F, 1'b0, lat, bc, d, e, ra);
        chk("wr_keeps_dout", 32'(dout0), 32'h1234);
        access(1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, lat, bc, d, e, ra);
        chk("rdoor_data", 32'(d),   32'h0);
        chk("rdoor_err",  32'(e),   32'h1);
        chk("rdoor_lat",  32'(lat), 32'd3);
        chk("err_clears", 32'(err0), 32'h0);
        access(1'b0, 1'b1, 16'h0100, 16'hDEAD, 1'b0, lat, bc, d, e, ra);
        chk("wroor_err", 32'(e), 32'h1);
        access(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, lat, bc, d, e, ra);
        chk("rd0_after_oor", 32'(d), 32'h0F0F);
        chk("rd0_err",       32'(e), 32'h0);

        // CS held high on reads of 0x0005: acceptance every 5 cycles.
        access(1'b0, 1'b1, 16'h0005, 16'h0505, 1'b0, lat, bc, d, e, ra);
        cs0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
        npulse = 0; consec = 0; prev = 1'b0;
        pos[0] = 0; pos[1] = 0; pos[2] = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge CLK);
            if (r0) begin
                if (npulse < 3) pos[npulse] = c;
                npulse++;
                if (prev) consec++;
            end
            prev = r0;
        end
        cs0 = 1'b0;
        chk("hold_npulse", 32'(npulse), 32'd3);
        chk("hold_pos0",   32'(pos[0]), 32'd4);
        chk("hold_pos1",   32'(pos[1]), 32'd9);
        chk("hold_pos2",   32'(pos[2]), 32'd14);
        chk("hold_consec", 32'(consec), 32'd0);
        chk("hold_data",   32'(dout0),  32'h0505);
        wd = 0;
        while (busy0 && wd < 20) begin @(negedge CLK); wd++; end
        chk("hold_drain_timeout", 32'(busy0), 32'h0);
        @(negedge CLK);

        // Address/data wiggled during WAIT must not redirect the write.
        access(1'b0, 1'b1, 16'h0002, 16'h2222, 1'b0, lat, bc, d, e, ra);
        access(1'b0, 1'b1, 16'h0003, 16'h3333, 1'b0, lat, bc, d, e, ra);
        access(1'b0, 1'b1, 16'h0001, 16'hAAAA, 1'b1, lat, bc, d, e, ra);
        access(1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, lat, bc, d, e, ra);
        chk("scr_mem1", 32'(d), 32'hAAAA);
        access(1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, lat, bc, d, e, ra);
        chk("scr_mem2", 32'(d), 32'h2222);
        access(1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, lat, bc, d, e, ra);
        chk("scr_mem3", 32'(d), 32'h3333);

        // WAIT_CYC=1 instance, written before the reset so it also checks retention.
        access(1'b1, 1'b1, 16'h0000, 16'h00C3, 1'b0, lat, bc, d, e, ra);
        chk("w1_wr_lat", 32'(lat), 32'd1);

        // Reset during WAIT aborts the write to 0x0020.
        access(1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0, lat, bc, d, e, ra);
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, bc, d, e, ra);
        cs0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; din0 = 16'hBEEF;
        @(negedge CLK);
        cs0 = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_busy", 32'(busy0), 32'h0);
        chk("abort_dout", 32'(dout0), 32'h0);
        chk("abort_err",  32'(err0),  32'h0);
        npulse = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (r0) npulse++;
        end
        chk("abort_no_r", 32'(npulse), 32'd0);
        access(1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, lat, bc, d, e, ra);
        chk("abort_mem20", 32'(d), 32'h5555);

        access(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, lat, bc, d, e, ra);
        chk("w1_rd_lat",  32'(lat), 32'd1);
        chk("w1_rd_busy", 32'(bc),  32'd2);
        chk("w1_rd_data", 32'(d),   32'h00C3);
        chk("w1_rd_rone", 32'(ra),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
